// File: rtl/exec_sequencer.sv
// -----------------------------------------------------------------------------
// exec_sequencer
//
// Multi-cycle control sequencer for the 16-bit SCC core. Each instruction
// moves through FETCH -> DECODE -> EXECUTE [-> MEMORY [-> WRITEBACK]]. The
// block drives the enables for the PC, IR, register file, flags register and
// data memory. It also runs the req/ack handshakes with instruction and data
// memory and traps into HALT or FAULT.
//
// Parameters
//   TIMEOUT  cycles to wait for imem_ack/dmem_ack before FAULT (2..255)
//   CNT_W    width of the handshake wait counter
//
// Ports
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   run                permits a new fetch when high
//   imem_ack           instruction memory data valid (1-cycle pulse)
//   dmem_ack           data memory access complete (1-cycle pulse)
//   special_encoding   decoded: 1 = ALU op
//   first_level[1:0]   decoded first-level field
//   alu_oc[2:0]        decoded op/ALU code
//   b_cond[3:0]        decoded branch condition
//   flags[3:0]         current {N,Z,C,V}
//   imem_req           fetch request
//   ir_load            latch instruction register
//   pc_inc / pc_load   PC <= PC+1 / PC <= branch target
//   rf_we / flags_we   register file / flags register write enables
//   dmem_req/dmem_we   data memory request / write qualifier
//   halted / fault     sticky HALT and handshake-timeout indications
//   state[2:0]         FETCH=0 DECODE=1 EXECUTE=2 MEMORY=3 WRITEBACK=4
//                      HALT=5 FAULT=6
// -----------------------------------------------------------------------------
module exec_sequencer #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       imem_ack,
    input  logic       dmem_ack,
    input  logic       special_encoding,
    input  logic [1:0] first_level,
    input  logic [2:0] alu_oc,
    input  logic [3:0] b_cond,
    input  logic [3:0] flags,
    output logic       imem_req,
    output logic       ir_load,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       rf_we,
    output logic       flags_we,
    output logic       dmem_req,
    output logic       dmem_we,
    output logic       halted,
    output logic       fault,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5,
        S_FAULT     = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        OP_ALU,
        OP_MOVE,
        OP_LOAD,
        OP_STORE,
        OP_B,
        OP_BCOND,
        OP_BR,
        OP_HALT,
        OP_NOP
    } op_t;

    // Last counter value before the handshake is declared dead.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    op_t  op_dec;
    logic cond_true;

    // Internal (ungated) outputs
    logic imem_req_c, ir_load_c, pc_inc_c, pc_load_c, rf_we_c, flags_we_c;
    logic dmem_req_c, dmem_we_c, halted_c, fault_c;

    // Instruction class decode; the ALU flag takes priority over first_level.
    always_comb begin
        op_dec = OP_NOP;
        if (special_encoding) begin
            op_dec = OP_ALU;
        end else if (first_level == 2'b00) begin
            op_dec = OP_MOVE;
        end else if (first_level == 2'b01) begin
            op_dec = alu_oc[0] ? OP_STORE : OP_LOAD;
        end else begin
            case (alu_oc)
                3'b000:  op_dec = OP_B;
                3'b001:  op_dec = OP_BCOND;
                3'b010:  op_dec = OP_BR;
                3'b111:  op_dec = OP_HALT;
                default: op_dec = OP_NOP;
            endcase
        end
    end

    // Branch condition against live flags {N,Z,C,V}
    always_comb begin
        logic n, z, c, v;
        {n, z, c, v} = flags;
        cond_true = 1'b0;
        case (b_cond)
            4'b0000: cond_true = z;
            4'b0001: cond_true = !z;
            4'b0010: cond_true = c;
            4'b0011: cond_true = !c;
            4'b0100: cond_true = n;
            4'b0101: cond_true = !n;
            4'b0110: cond_true = v;
            4'b0111: cond_true = !v;
            4'b1000: cond_true = c & !z;
            4'b1001: cond_true = (n == v);
            4'b1010: cond_true = (n != v);
            4'b1011: cond_true = !z & (n == v);
            4'b1110: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            op_q    <= OP_NOP;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cnt_d      = '0;
        imem_req_c = 1'b0;
        ir_load_c  = 1'b0;
        pc_inc_c   = 1'b0;
        pc_load_c  = 1'b0;
        rf_we_c    = 1'b0;
        flags_we_c = 1'b0;
        dmem_req_c = 1'b0;
        dmem_we_c  = 1'b0;
        halted_c   = 1'b0;
        fault_c    = 1'b0;

        case (state_q)
            S_FETCH: begin
                imem_req_c = run;
                if (run) begin
                    if (imem_ack) begin
                        ir_load_c = 1'b1;
                        pc_inc_c  = 1'b1;
                        state_d   = S_DECODE;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = S_FAULT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_DECODE: begin
                op_d    = op_dec;
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                state_d = S_FETCH;
                case (op_q)
                    OP_ALU: begin
                        rf_we_c    = 1'b1;
                        flags_we_c = 1'b1;
                    end
                    OP_MOVE:            rf_we_c   = 1'b1;
                    OP_LOAD, OP_STORE:  state_d   = S_MEMORY;
                    OP_B, OP_BR:        pc_load_c = 1'b1;
                    OP_BCOND:           pc_load_c = cond_true;
                    OP_HALT:            state_d   = S_HALT;
                    default:            ;
                endcase
            end
            S_MEMORY: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = (op_q == OP_STORE);
                if (dmem_ack) begin
                    state_d = (op_q == OP_STORE) ? S_FETCH : S_WRITEBACK;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_FAULT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WRITEBACK: begin
                rf_we_c = 1'b1;
                state_d = S_FETCH;
            end
            S_HALT:  halted_c = 1'b1;
            S_FAULT: fault_c  = 1'b1;
            default: state_d  = S_FAULT;
        endcase
    end

    // Gating with rst_n forces every output low while reset is asserted,
    // including imem_req, which would otherwise follow run in FETCH.
    assign imem_req = imem_req_c & rst_n;
    assign ir_load  = ir_load_c  & rst_n;
    assign pc_inc   = pc_inc_c   & rst_n;
    assign pc_load  = pc_load_c  & rst_n;
    assign rf_we    = rf_we_c    & rst_n;
    assign flags_we = flags_we_c & rst_n;
    assign dmem_req = dmem_req_c & rst_n;
    assign dmem_we  = dmem_we_c  & rst_n;
    assign halted   = halted_c   & rst_n;
    assign fault    = fault_c    & rst_n;
    assign state    = state_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// -----------------------------------------------------------------------------
// tb_exec_sequencer
//
// Directed bench for exec_sequencer. Each step drives inputs just after a
// rising edge and pushes the expected output vector onto a scoreboard queue.
// Mid-cycle, the bench pops that vector and checks it against the DUT outputs
// with an immediate assertion.
// Vector layout: {state[2:0], imem_req, ir_load, pc_inc, pc_load, rf_we,
//                 flags_we, dmem_req, dmem_we, halted, fault}
// -----------------------------------------------------------------------------
module tb_exec_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run, imem_ack, dmem_ack, special_encoding;
    logic [1:0] first_level;
    logic [2:0] alu_oc;
    logic [3:0] b_cond, flags;
    logic       imem_req, ir_load, pc_inc, pc_load, rf_we, flags_we;
    logic       dmem_req, dmem_we, halted, fault;
    logic [2:0] state;

    int compared   = 0;
    int mismatched = 0;

    logic [12:0] exp_q[$];
    string       tag_q[$];

    localparam logic [9:0] M_NONE = 10'h000;
    localparam logic [9:0] M_IMEM = 10'h200;
    localparam logic [9:0] M_IR   = 10'h100;
    localparam logic [9:0] M_PCI  = 10'h080;
    localparam logic [9:0] M_PCL  = 10'h040;
    localparam logic [9:0] M_RF   = 10'h020;
    localparam logic [9:0] M_FL   = 10'h010;
    localparam logic [9:0] M_DREQ = 10'h008;
    localparam logic [9:0] M_DWE  = 10'h004;
    localparam logic [9:0] M_HLT  = 10'h002;
    localparam logic [9:0] M_FLT  = 10'h001;

    exec_sequencer #(.TIMEOUT(16), .CNT_W(8)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .run              (run),
        .imem_ack         (imem_ack),
        .dmem_ack         (dmem_ack),
        .special_encoding (special_encoding),
        .first_level      (first_level),
        .alu_oc           (alu_oc),
        .b_cond           (b_cond),
        .flags            (flags),
        .imem_req         (imem_req),
        .ir_load          (ir_load),
        .pc_inc           (pc_inc),
        .pc_load          (pc_load),
        .rf_we            (rf_we),
        .flags_we         (flags_we),
        .dmem_req         (dmem_req),
        .dmem_we          (dmem_we),
        .halted           (halted),
        .fault            (fault),
        .state            (state)
    );

    always #5 clk = ~clk;

    function automatic logic [12:0] ev(input logic [2:0] st, input logic [9:0] m);
        return {st, m};
    endfunction

    // Pop one expectation and compare with the current DUT outputs.
    task automatic check();
        logic [12:0] obs, expv;
        string       tag;
        obs  = {state, imem_req, ir_load, pc_inc, pc_load, rf_we, flags_we,
                dmem_req, dmem_we, halted, fault};
        expv = exp_q.pop_front();
        tag  = tag_q.pop_front();
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    // One clock step: inputs already driven at posedge+1; sample at posedge+4.
    task automatic cyc(input logic [12:0] expv, input string tag);
        exp_q.push_back(expv);
        tag_q.push_back(tag);
        #3;
        check();
        @(posedge clk);
        #1;
        $display("step %-14s state=%0d outs=%b", tag, state,
                 {imem_req, ir_load, pc_inc, pc_load, rf_we, flags_we,
                  dmem_req, dmem_we, halted, fault});
    endtask

    // Asynchronous reset pulse: outputs must drop within the same cycle.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        exp_q.push_back(ev(3'd0, M_NONE));
        tag_q.push_back(tag);
        check();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic set_op(input logic se, input logic [1:0] fl, input logic [2:0] oc);
        special_encoding = se;
        first_level      = fl;
        alu_oc           = oc;
    endtask

    // Fetch acknowledged at once, followed by the DECODE cycle.
    task automatic fetch_decode(input string tag);
        imem_ack = 1'b1;
        cyc(ev(3'd0, M_IMEM | M_IR | M_PCI), {tag, "_fetch"});
        imem_ack = 1'b0;
        cyc(ev(3'd1, M_NONE), {tag, "_decode"});
    endtask

    task automatic branch(input logic [2:0] oc, input logic [3:0] bc,
                          input logic [3:0] fl, input logic taken, input string tag);
        set_op(1'b0, 2'b10, oc);
        b_cond = bc;
        flags  = fl;
        fetch_decode(tag);
        cyc(ev(3'd2, taken ? M_PCL : M_NONE), {tag, "_exec"});
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
        special_encoding = 1'b0; first_level = 2'b00; alu_oc = 3'b000;
        b_cond = 4'b0000; flags = 4'b0000;

        // Outputs stay low under reset even though run=1.
        #2;
        exp_q.push_back(ev(3'd0, M_NONE));
        tag_q.push_back("reset_state");
        check();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // ALU op: ack on second FETCH cycle, writes two cycles later.
        set_op(1'b1, 2'b00, 3'b001);
        cyc(ev(3'd0, M_IMEM), "alu_fetch1");
        fetch_decode("alu");
        cyc(ev(3'd2, M_RF | M_FL), "alu_exec");

        // MOVE/SHIFT: rf_we only.
        set_op(1'b0, 2'b00, 3'b011);
        fetch_decode("move");
        cyc(ev(3'd2, M_RF), "move_exec");

        // Load with dmem_ack on the third MEMORY cycle.
        set_op(1'b0, 2'b01, 3'b000);
        fetch_decode("load");
        cyc(ev(3'd2, M_NONE), "load_exec");
        cyc(ev(3'd3, M_DREQ), "load_mem1");
        cyc(ev(3'd3, M_DREQ), "load_mem2");
        dmem_ack = 1'b1;
        cyc(ev(3'd3, M_DREQ), "load_mem3");
        dmem_ack = 1'b0;
        cyc(ev(3'd4, M_RF), "load_wb");

        // Store acknowledged immediately: no writeback.
        set_op(1'b0, 2'b01, 3'b001);
        fetch_decode("store");
        cyc(ev(3'd2, M_NONE), "store_exec");
        dmem_ack = 1'b1;
        cyc(ev(3'd3, M_DREQ | M_DWE), "store_mem");
        dmem_ack = 1'b0;
        cyc(ev(3'd0, M_IMEM), "store_after");

        // Branches
        branch(3'b001, 4'b0000, 4'b0100, 1'b1, "bc_z_taken");
        branch(3'b001, 4'b0000, 4'b0000, 1'b0, "bc_z_not");
        branch(3'b001, 4'b1011, 4'b1001, 1'b1, "bc_gt_taken");
        branch(3'b001, 4'b1000, 4'b0010, 1'b1, "bc_hi_taken");
        branch(3'b001, 4'b1110, 4'b0000, 1'b1, "bc_always");
        branch(3'b001, 4'b1111, 4'b1111, 1'b0, "bc_never");
        branch(3'b000, 4'b1111, 4'b0000, 1'b1, "b_uncond");
        branch(3'b011, 4'b1110, 4'b0000, 1'b0, "ctrl_nop");

        // Some request cycles, then run=0 holds FETCH, ignores ack, clears count.
        cyc(ev(3'd0, M_IMEM), "pre_hold1");
        cyc(ev(3'd0, M_IMEM), "pre_hold2");
        run = 1'b0;
        imem_ack = 1'b1;
        cyc(ev(3'd0, M_NONE), "hold_ack_ign");
        imem_ack = 1'b0;
        cyc(ev(3'd0, M_NONE), "hold");
        run = 1'b1;

        // Ack on the final permitted cycle wins over the timeout.
        set_op(1'b1, 2'b00, 3'b000);
        for (int i = 0; i < 15; i++) cyc(ev(3'd0, M_IMEM), "tmo_edge_wait");
        fetch_decode("tmo_edge");
        cyc(ev(3'd2, M_RF | M_FL), "tmo_edge_exec");

        // Withheld ack: FAULT after exactly 16 request cycles.
        for (int i = 0; i < 16; i++) cyc(ev(3'd0, M_IMEM), "tmo_wait");
        cyc(ev(3'd6, M_FLT), "fault_entry");
        imem_ack = 1'b1;
        cyc(ev(3'd6, M_FLT), "fault_ack_ign");
        imem_ack = 1'b0;
        cyc(ev(3'd6, M_FLT), "fault_sticky");
        do_reset("fault_reset");
        cyc(ev(3'd0, M_IMEM), "post_fault");

        // HALT is sticky regardless of run or acks.
        set_op(1'b0, 2'b10, 3'b111);
        fetch_decode("halt");
        cyc(ev(3'd2, M_NONE), "halt_exec");
        for (int i = 0; i < 22; i++) begin
            run      = 1'($urandom_range(0, 1));
            imem_ack = 1'($urandom_range(0, 1));
            dmem_ack = 1'($urandom_range(0, 1));
            cyc(ev(3'd5, M_HLT), "halted");
        end
        run = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
        do_reset("halt_reset");

        // Reset asserted while a load waits in MEMORY.
        set_op(1'b0, 2'b01, 3'b000);
        fetch_decode("rstmem");
        cyc(ev(3'd2, M_NONE), "rstmem_exec");
        cyc(ev(3'd3, M_DREQ), "rstmem_mem");
        do_reset("rstmem_reset");
        cyc(ev(3'd0, M_IMEM), "rstmem_after1");
        cyc(ev(3'd0, M_IMEM), "rstmem_after2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
Multi-cycle control sequencer for the 16-bit SCC core. It steps each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK, and emits the enables that drive the PC, IR, register file, flags register and data memory around the EX datapath. It evaluates branch conditions against the flags, handles req/ack handshakes with instruction and data memory, and traps on handshake timeout or HALT.

Parameters:
TIMEOUT, 16, max cycles to wait for imem_ack/dmem_ack before entering FAULT (range 2..255)
CNT_W, 8, width of the wait counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
run  input  1  permits a new fetch when high
imem_ack  input  1  instruction memory data valid, one-cycle pulse
dmem_ack  input  1  data memory access complete, one-cycle pulse
special_encoding  input  1  decoded: 1 = ALU op
first_level  input  2  decoded first-level field
alu_oc  input  3  decoded op/ALU code
b_cond  input  4  decoded branch condition
flags  input  4  current {N,Z,C,V}
imem_req  output  1  fetch request
ir_load  output  1  latch instruction register
pc_inc  output  1  PC <= PC+1
pc_load  output  1  PC <= branch target
rf_we  output  1  register file write enable
flags_we  output  1  flags register write enable
dmem_req  output  1  data memory request
dmem_we  output  1  data memory write (valid with dmem_req)
halted  output  1  core in HALT
fault  output  1  handshake timeout trap
state  output  3  FETCH=0 DECODE=1 EXECUTE=2 MEMORY=3 WRITEBACK=4 HALT=5 FAULT=6

Behaviour:
- Reset: state=FETCH, wait counter=0, all outputs 0. Reset asserted mid-instruction or mid-handshake aborts immediately, with no pulses.
- Instruction classes, sampled in DECODE and registered for the rest of the instruction:
  - ALU: special_encoding=1.
  - MOVE/SHIFT: special_encoding=0, first_level=00.
  - MEM: first_level=01; alu_oc[0]=1 is a store, 0 is a load.
  - CTRL: first_level=1x; alu_oc 000 = B, 001 = B.cond, 010 = BR, 111 = HALT, anything else = NOP.
- FETCH:
  - imem_req=run. Counter increments each cycle with imem_req=1 and no ack.
  - On imem_ack with imem_req: ir_load=1 and pc_inc=1 for that cycle, counter clears, go to DECODE.
  - An ack arriving while imem_req=0 is ignored.
  - counter reaching TIMEOUT-1 with no ack: go to FAULT. An ack on that same cycle wins and there is no fault.
  - run=0 holds FETCH and clears the counter.
- DECODE: always 1 cycle, then EXECUTE.
- EXECUTE (1 cycle):
  - ALU: rf_we=1, flags_we=1, then FETCH.
  - MOVE/SHIFT: rf_we=1, flags_we=0, then FETCH.
  - MEM: then MEMORY.
  - B and BR: pc_load=1. B.cond: pc_load=cond_true. Both then FETCH.
  - HALT: then HALT. NOP: then FETCH.
- cond_true by b_cond:
  - 0000 Z; 0001 !Z; 0010 C; 0011 !C; 0100 N; 0101 !N; 0110 V; 0111 !V.
  - 1000 C&!Z; 1001 N==V; 1010 N!=V; 1011 !Z&(N==V).
  - 1110 always; 1100, 1101, 1111 never.
  - Flags are sampled in the EXECUTE cycle.
- MEMORY:
  - dmem_req=1, and dmem_we=1 for a store, held until dmem_ack. Same timeout rule as FETCH.
  - On ack: a store goes to FETCH, a load goes to WRITEBACK.
- WRITEBACK: rf_we=1 for 1 cycle, then FETCH.
- HALT: halted=1; sticky until reset; all requests 0.
- FAULT: fault=1; sticky until reset; all requests 0.
- pc_inc and pc_load are never asserted in the same cycle. rf_we is never asserted outside EXECUTE or WRITEBACK.
- Minimum latency with same-cycle acks:
  - ALU, MOVE and branch instructions: 3 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.

Test Plan:
- Reset release, run=1, imem_ack on 2nd FETCH cycle, ALU op (special_encoding=1, alu_oc=001) -> ir_load/pc_inc pulse on the ack cycle; rf_we=flags_we=1 exactly 2 cycles later; state returns to 0.
- Load (first_level=01, alu_oc=000), dmem_ack 3 cycles after entering MEMORY -> dmem_req high 3 cycles with dmem_we=0, then rf_we pulse in WRITEBACK; store (alu_oc=001) -> dmem_we=1 with req, and no rf_we.
- B.cond b_cond=0000: flags=0100 -> pc_load=1 in EXECUTE; flags=0000 -> pc_load=0. b_cond=1011 with flags=1001 (N=V, Z=0) -> pc_load=1.
- imem_ack withheld with TIMEOUT=16 -> fault=1 and state=6 after 16 request cycles; later acks are ignored; rst_n low clears everything.
- HALT (first_level=10, alu_oc=111) -> halted=1, imem_req stays 0 for 20+ cycles; run toggling has no effect.
- rst_n pulsed low during MEMORY with dmem_req=1 -> outputs 0 immediately (asynchronous); after release, state=FETCH and no stray rf_we.
